// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: directory entry layout, directory/scheduler state encodings and sizing constants.
package apb2axi_pkg;
  localparam int DIR_ENTRIES = 16;
  localparam int TAG_W = $clog2(DIR_ENTRIES);
  typedef enum logic [1:0] {DIR_ST_EMPTY, DIR_ST_PENDING, DIR_ST_ISSUED, DIR_ST_DONE} dir_state_e;
  typedef struct packed {
    logic             is_write;
    logic [TAG_W-1:0] tag;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
  } directory_entry_t;
  localparam int REQ_WIDTH = $bits(directory_entry_t);
  typedef enum logic [1:0] {SCH_IDLE, SCH_FETCH, SCH_ISSUE} sched_state_e;
endpackage

// File: rtl/apb2axi_rr_arbiter.sv
// apb2axi_rr_arbiter: picks the first requester at or after ptr (wrapping), as one-hot and index.
module apb2axi_rr_arbiter #(
  parameter int N = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  assign rot = N'({req, req} >> ptr);
  assign any = |req;
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  end
  assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/apb2axi_issue_sched.sv
// apb2axi_issue_sched: round-robin issue of pending directory slots to AR/AW builders; APB2AXI_SCHED_PERF_EN adds perf counters.
module apb2axi_issue_sched
  import apb2axi_pkg::*;
#(
  parameter int N_ENTRIES = DIR_ENTRIES,
  parameter int MAX_RD_OUT = 8,
  parameter int MAX_WR_OUT = 8,
  localparam int RCW = $clog2(MAX_RD_OUT + 1),
  localparam int WCW = $clog2(MAX_WR_OUT + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N_ENTRIES-1:0] dir_pending,
  input  logic [N_ENTRIES-1:0] dir_is_write,
  output logic [TAG_W-1:0]     dir_rd_tag,
  input  logic [REQ_WIDTH-1:0] dir_rd_entry,
  output logic                 issued_valid,
  output logic [TAG_W-1:0]     issued_tag,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [REQ_WIDTH-1:0] req_entry,
  input  logic                 cpl_valid,
  input  logic                 cpl_is_write,
  output logic [RCW-1:0]       rd_out_cnt,
  output logic [WCW-1:0]       wr_out_cnt
`ifdef APB2AXI_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issued_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);
  sched_state_e         state, state_nx;
  directory_entry_t     req_q;
  logic [TAG_W-1:0]     rr_ptr, grant_idx;
  logic [N_ENTRIES-1:0] req, grant, excl;
  logic                 any, hs, rd_ok, wr_ok, rd_inc, rd_dec, wr_inc, wr_dec;
  assign req_entry = req_q;
  assign rd_ok = rd_out_cnt < RCW'(MAX_RD_OUT);
  assign wr_ok = wr_out_cnt < WCW'(MAX_WR_OUT);
  assign excl = issued_valid ? N_ENTRIES'(1) << issued_tag : '0;
  assign req = dir_pending & ~excl & ((dir_is_write & {N_ENTRIES{wr_ok}}) | (~dir_is_write & {N_ENTRIES{rd_ok}}));
  apb2axi_rr_arbiter #(.N(N_ENTRIES), .IW(TAG_W)) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(grant_idx),
    .any(any)
  );
  assign ar_valid = state == SCH_ISSUE && !req_q.is_write;
  assign aw_valid = state == SCH_ISSUE && req_q.is_write;
  assign hs = (ar_valid && ar_ready) || (aw_valid && aw_ready);
  assign rd_inc = hs && !req_q.is_write;
  assign wr_inc = hs && req_q.is_write;
  assign rd_dec = cpl_valid && !cpl_is_write;
  assign wr_dec = cpl_valid && cpl_is_write;
  always_comb begin
    state_nx = (state == SCH_IDLE) ? (any ? SCH_FETCH : SCH_IDLE) :
               (state == SCH_FETCH) ? SCH_ISSUE : (hs ? SCH_IDLE : SCH_ISSUE);
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= SCH_IDLE;
      rr_ptr <= '0;
      dir_rd_tag <= '0;
      req_q <= '0;
      issued_valid <= 1'b0;
      issued_tag <= '0;
      rd_out_cnt <= '0;
      wr_out_cnt <= '0;
    end else begin
      state <= state_nx;
      issued_valid <= hs;
      if (hs) issued_tag <= dir_rd_tag;
      if (state == SCH_IDLE && any) begin
        dir_rd_tag <= grant_idx;
        rr_ptr <= (grant_idx == TAG_W'(N_ENTRIES - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == SCH_FETCH) req_q <= dir_rd_entry;
      rd_out_cnt <= (rd_inc && !rd_dec && rd_ok) ? rd_out_cnt + 1'b1 :
                    (rd_dec && !rd_inc && |rd_out_cnt) ? rd_out_cnt - 1'b1 : rd_out_cnt;
      wr_out_cnt <= (wr_inc && !wr_dec && wr_ok) ? wr_out_cnt + 1'b1 :
                    (wr_dec && !wr_inc && |wr_out_cnt) ? wr_out_cnt - 1'b1 : wr_out_cnt;
    end
  end
`ifdef APB2AXI_SCHED_PERF_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      perf_issued_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_issued_cnt <= perf_issued_cnt + 32'(hs);
      perf_stall_cnt <= perf_stall_cnt + 32'(state == SCH_ISSUE && !hs);
    end
  end
`endif
  assert property (@(posedge aclk) disable iff (!aresetn) !(rd_dec && !rd_inc && rd_out_cnt == '0));
  assert property (@(posedge aclk) disable iff (!aresetn) !(wr_dec && !wr_inc && wr_out_cnt == '0));
  assert property (@(posedge aclk) disable iff (!aresetn) !(rd_inc && !rd_dec && !rd_ok));
  assert property (@(posedge aclk) disable iff (!aresetn) !(wr_inc && !wr_dec && !wr_ok));
  assert property (@(posedge aclk) disable iff (!aresetn) (state == SCH_IDLE && any) |-> $onehot(grant));
endmodule

// File: tb/tb_apb2axi_issue_sched.sv
// tb_apb2axi_issue_sched: directed self-checking bench for the issue scheduler.
module tb_apb2axi_issue_sched;
  import apb2axi_pkg::*;
  logic                 aclk = 1'b0, aresetn = 1'b0;
  logic [15:0]          pend = '0, wr_m = '0;
  logic [TAG_W-1:0]     dir_rd_tag, issued_tag;
  logic [REQ_WIDTH-1:0] dir_rd_entry, req_entry, saved;
  logic                 issued_valid, ar_valid, aw_valid;
  logic                 ar_ready = 1'b0, aw_ready = 1'b0, cpl_valid = 1'b0, cpl_is_write = 1'b0;
  logic [1:0]           rd_out_cnt;
  logic [3:0]           wr_out_cnt;
  int                   n_cmp = 0, n_err = 0, base;
  bit                   auto_cpl = 1'b0, ok;
  logic [3:0]           iss_q[$];
  directory_entry_t     ex;
  typedef struct {
    logic [3:0]  tag;
    logic        wr;
    logic [31:0] addr;
    logic        ar;
    logic        aw;
  } vec_t;
  vec_t tbl[5];

  apb2axi_issue_sched #(.N_ENTRIES(16), .MAX_RD_OUT(2), .MAX_WR_OUT(8)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .dir_pending(pend),
    .dir_is_write(wr_m),
    .dir_rd_tag(dir_rd_tag),
    .dir_rd_entry(dir_rd_entry),
    .issued_valid(issued_valid),
    .issued_tag(issued_tag),
    .ar_valid(ar_valid),
    .ar_ready(ar_ready),
    .aw_valid(aw_valid),
    .aw_ready(aw_ready),
    .req_entry(req_entry),
    .cpl_valid(cpl_valid),
    .cpl_is_write(cpl_is_write),
    .rd_out_cnt(rd_out_cnt),
    .wr_out_cnt(wr_out_cnt)
  );

  always #5 aclk = ~aclk;

  function automatic logic [REQ_WIDTH-1:0] mk(logic [3:0] t, logic w);
    directory_entry_t e;
    e.is_write = w;
    e.tag = t;
    e.addr = 32'h1000 + {24'h0, t, 4'h0};
    e.len = {4'h0, t};
    e.size = 3'd2;
    return e;
  endfunction
  assign dir_rd_entry = mk(dir_rd_tag, wr_m[dir_rd_tag]);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic pv;
    logic [3:0] pt;
    pv = issued_valid;
    pt = issued_tag;
    if (auto_cpl) begin
      cpl_valid = issued_valid;
      cpl_is_write = wr_m[issued_tag];
    end
    @(posedge aclk);
    #1;
    if (pv === 1'b1) pend[pt] = 1'b0;
    if (issued_valid === 1'b1) iss_q.push_back(issued_tag);
  endtask

  task automatic wait_iss(string nm, int target, int budget);
    int b;
    b = budget;
    while (iss_q.size() < target && b > 0) begin
      tick();
      b--;
    end
    chk({nm, " issue count"}, 64'(iss_q.size()), 64'(target));
  endtask

  task automatic do_reset();
    pend = '0;
    wr_m = '0;
    ar_ready = 1'b0;
    aw_ready = 1'b0;
    cpl_valid = 1'b0;
    auto_cpl = 1'b0;
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    iss_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{tag: 4'd0,  wr: 1'b0, addr: 32'h1000, ar: 1'b1, aw: 1'b0};
    tbl[1] = '{tag: 4'd5,  wr: 1'b1, addr: 32'h1050, ar: 1'b0, aw: 1'b1};
    tbl[2] = '{tag: 4'd15, wr: 1'b0, addr: 32'h10F0, ar: 1'b1, aw: 1'b0};
    tbl[3] = '{tag: 4'd8,  wr: 1'b1, addr: 32'h1080, ar: 1'b0, aw: 1'b1};
    tbl[4] = '{tag: 4'd12, wr: 1'b1, addr: 32'h10C0, ar: 1'b0, aw: 1'b1};

    pend = '1;
    repeat (3) tick();
    chk("reset outputs", {ar_valid, aw_valid, issued_valid, issued_tag, dir_rd_tag, rd_out_cnt, wr_out_cnt}, 64'h0);
    chk("reset req_entry", req_entry, 64'h0);
    aresetn = 1'b1;
    tick();
    tick();
    chk("first grant ar_valid", {ar_valid, aw_valid}, 64'h2);
    ex = '{is_write: 1'b0, tag: 4'd0, addr: 32'h1000, len: 8'd0, size: 3'd2};
    chk("first grant entry", req_entry, ex);
    do_reset();

    ar_ready = 1'b1;
    aw_ready = 1'b1;
    foreach (tbl[i]) begin
      base = iss_q.size();
      pend[tbl[i].tag] = 1'b1;
      wr_m[tbl[i].tag] = tbl[i].wr;
      tick();
      tick();
      chk($sformatf("vec%0d valids", i), {ar_valid, aw_valid}, {tbl[i].ar, tbl[i].aw});
      ex = '{is_write: tbl[i].wr, tag: tbl[i].tag, addr: tbl[i].addr, len: {4'h0, tbl[i].tag}, size: 3'd2};
      chk($sformatf("vec%0d req_entry", i), req_entry, ex);
      chk($sformatf("vec%0d dir_rd_tag", i), dir_rd_tag, tbl[i].tag);
      tick();
      chk($sformatf("vec%0d issued", i), {issued_valid, issued_tag}, {1'b1, tbl[i].tag});
      chk($sformatf("vec%0d cnt after issue", i), tbl[i].wr ? wr_out_cnt : {2'b0, rd_out_cnt}, 64'd1);
      cpl_valid = 1'b1;
      cpl_is_write = tbl[i].wr;
      tick();
      cpl_valid = 1'b0;
      repeat (4) tick();
      chk($sformatf("vec%0d single pulse", i), 64'(iss_q.size() - base), 64'd1);
      chk($sformatf("vec%0d cnt after cpl", i), {rd_out_cnt, wr_out_cnt}, 64'h0);
    end

    do_reset();
    ar_ready = 1'b1;
    aw_ready = 1'b1;
    auto_cpl = 1'b1;
    pend[3] = 1'b1;
    pend[7] = 1'b1;
    pend[12] = 1'b1;
    wait_iss("rr", 3, 40);
    chk("rr order", {iss_q[0], iss_q[1], iss_q[2]}, {4'd3, 4'd7, 4'd12});
    repeat (2) tick();
    pend[3] = 1'b1;
    pend[7] = 1'b1;
    wait_iss("rr wrap", 5, 40);
    chk("rr wrap order", {iss_q[3], iss_q[4]}, {4'd3, 4'd7});
    repeat (2) tick();
    auto_cpl = 1'b0;
    cpl_valid = 1'b0;
    tick();
    chk("rr counters", {rd_out_cnt, wr_out_cnt}, 64'h0);

    base = iss_q.size();
    aw_ready = 1'b0;
    pend[5] = 1'b1;
    wr_m[5] = 1'b1;
    tick();
    tick();
    chk("bp aw_valid", {ar_valid, aw_valid}, 64'h1);
    saved = req_entry;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (aw_valid !== 1'b1 || ar_valid !== 1'b0 || req_entry !== saved || issued_valid !== 1'b0) ok = 1'b0;
    end
    chk("bp stable", 64'(ok), 64'd1);
    ex = '{is_write: 1'b1, tag: 4'd5, addr: 32'h1050, len: 8'd5, size: 3'd2};
    chk("bp entry", saved, ex);
    aw_ready = 1'b1;
    tick();
    chk("bp issued", {issued_valid, issued_tag}, {1'b1, 4'd5});
    chk("bp wr_out_cnt", wr_out_cnt, 64'd1);
    repeat (4) tick();
    chk("bp single pulse", 64'(iss_q.size() - base), 64'd1);
    cpl_valid = 1'b1;
    cpl_is_write = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("bp cpl", wr_out_cnt, 64'd0);

    base = iss_q.size();
    pend[1] = 1'b1;
    pend[4] = 1'b1;
    pend[6] = 1'b1;
    pend[10] = 1'b1;
    repeat (20) tick();
    chk("credit cap count", 64'(iss_q.size() - base), 64'd2);
    chk("credit cap rd_out_cnt", rd_out_cnt, 64'd2);
    chk("credit cap idle", {ar_valid, aw_valid}, 64'h0);
    chk("credit order", {iss_q[base], iss_q[base+1]}, {4'd6, 4'd10});
    cpl_valid = 1'b1;
    cpl_is_write = 1'b0;
    tick();
    cpl_valid = 1'b0;
    repeat (10) tick();
    chk("credit refill count", 64'(iss_q.size() - base), 64'd3);
    chk("credit refill tag", iss_q[base+2], 64'd1);
    chk("credit refill rd_out_cnt", rd_out_cnt, 64'd2);

    do_reset();
    ar_ready = 1'b1;
    pend[2] = 1'b1;
    tick();
    tick();
    tick();
    chk("simul first issue", {issued_valid, issued_tag}, {1'b1, 4'd2});
    chk("simul rd_out_cnt 1", rd_out_cnt, 64'd1);
    pend[11] = 1'b1;
    tick();
    tick();
    chk("simul ar pending", {ar_valid, dir_rd_tag}, {1'b1, 4'd11});
    cpl_valid = 1'b1;
    cpl_is_write = 1'b0;
    tick();
    cpl_valid = 1'b0;
    chk("simul issued", {issued_valid, issued_tag}, {1'b1, 4'd11});
    chk("simul rd_out_cnt", rd_out_cnt, 64'd1);

    do_reset();
    pend[2] = 1'b1;
    pend[9] = 1'b1;
    wr_m[9] = 1'b1;
    tick();
    tick();
    chk("mixed ar first", {ar_valid, aw_valid}, 64'h2);
    aresetn = 1'b0;
    tick();
    chk("mixed reset drop", {ar_valid, aw_valid, issued_valid, rd_out_cnt, wr_out_cnt}, 64'h0);
    aresetn = 1'b1;
    ar_ready = 1'b1;
    aw_ready = 1'b1;
    wait_iss("mixed", 2, 30);
    chk("mixed order", {iss_q[0], iss_q[1]}, {4'd2, 4'd9});
    chk("mixed counters", {rd_out_cnt, wr_out_cnt}, {2'd1, 4'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
